// File: rtl/img_mem_pkg.sv
// Shared constants and types for the image memory responder.
// The default geometry is one CIF frame (352x288, 8-bit pixels packed four
// per word). The input image sits at word 0 and the result image directly
// above it.
package img_mem_pkg;

  localparam int IMG_W         = 352;
  localparam int IMG_H         = 288;
  localparam int WORDS_PER_IMG = IMG_W * IMG_H / 4;
  localparam int DEF_ADDR_W    = 16;
  localparam int DEF_DEPTH     = 2 * WORDS_PER_IMG;
  localparam int DEF_DUMP_BASE = WORDS_PER_IMG;

  typedef enum logic [1:0] {IDLE, RD, SEND, DONE} state_e;

endpackage

// File: rtl/img_mem_ram.sv
// Single-port synchronous word RAM with a registered read port.
// Ports:
//   clk    - rising-edge clock
//   en     - access enable
//   we     - write enable, qualified by en
//   addr   - word address; addresses >= DEPTH drop writes and read back 0
//   wdata  - write data
//   rdata  - read data, registered; it changes only on a read
// There is no reset, so that the array maps onto block RAM and keeps its
// contents across a controller reset.
module img_mem_ram #(
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 50688
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0] mem [DEPTH];
  logic        in_range;

  assign in_range = 32'(addr) < 32'(DEPTH);

  always_ff @(posedge clk) begin
    if (en) begin
      if (in_range) begin
        if (we) mem[addr[IDX_W-1:0]] <= wdata;
        else    rdata <= mem[addr[IDX_W-1:0]];
      end else if (!we) begin
        rdata <= '0;
      end
    end
  end

endmodule

// File: rtl/img_mem_responder.sv
// Responder end of the accelerator memory interface. It serves accelerator
// word accesses in IDLE. On a rising edge of dump_image it streams the
// result image region out as bytes over a valid/ready port.
// Ports:
//   clk, reset                  - clock; asynchronous active-low reset
//   en, we, addr, dataW, dataR  - accelerator port; dataR has 1-cycle read latency
//   dump_image                  - rising edge starts a dump (seen only in IDLE)
//   busy                        - dump in progress; accelerator accesses are ignored
//   out_data/valid/ready/last   - byte stream, byte 0 = bits 7:0 of each word
//   dump_done                   - one-cycle pulse after the final byte is accepted
module img_mem_responder
  import img_mem_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int DUMP_BASE  = DEF_DUMP_BASE,
  parameter int DUMP_WORDS = WORDS_PER_IMG
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       dataW,
  output logic [31:0]       dataR,
  input  logic              dump_image,
  output logic              busy,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              dump_done
);

  if (DUMP_BASE + DUMP_WORDS > DEPTH) begin : g_cfg_chk
    $error("img_mem_responder: DUMP_BASE + DUMP_WORDS exceeds DEPTH");
  end

  state_e            state;
  logic              dump_q;
  logic              rise;
  logic [ADDR_W-1:0] w, w_nxt;
  logic [1:0]        b;
  logic              acc;
  logic              acc_rd_q;
  logic [31:0]       rd_hold;
  logic              done_q;
  logic              ram_en, ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_rdata;

  assign rise  = dump_image & ~dump_q;
  assign acc   = (state == IDLE) & en;
  assign w_nxt = w + ADDR_W'(1);

  // The dump FSM owns the RAM port in RD. In every other state only IDLE
  // accesses reach the RAM.
  always_comb begin
    ram_en   = acc | (state == RD);
    ram_we   = acc & we;
    ram_addr = (state == RD) ? ADDR_W'(DUMP_BASE) + w : addr;
  end

  img_mem_ram #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (dataW),
    .rdata (ram_rdata)
  );

  // The RAM output register is shared with dump reads. dataR follows it
  // only in the cycle after an accelerator read. That value is then
  // snapshotted, so dump traffic never disturbs what the accelerator sees.
  assign dataR = acc_rd_q ? ram_rdata : rd_hold;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      dump_q   <= 1'b0;
      w        <= '0;
      b        <= '0;
      acc_rd_q <= 1'b0;
      rd_hold  <= '0;
      done_q   <= 1'b0;
    end else begin
      dump_q   <= dump_image;
      done_q   <= 1'b0;
      acc_rd_q <= acc & ~we;
      if (acc_rd_q) rd_hold <= ram_rdata;
      case (state)
        IDLE: if (rise) begin
          w     <= '0;
          state <= RD;
        end
        RD: begin
          b     <= '0;
          state <= SEND;
        end
        SEND: if (out_ready) begin
          b <= b + 2'd1;
          if (b == 2'd3) begin
            w <= w_nxt;
            if (w_nxt == ADDR_W'(DUMP_WORDS)) begin
              state  <= DONE;
              done_q <= 1'b1;
            end else begin
              state <= RD;
            end
          end
        end
        DONE: if (!dump_image) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // The word stays in the RAM output register for all of SEND, so the
  // byte is stable under backpressure without a separate shift register.
  always_comb begin
    busy      = (state == RD) | (state == SEND);
    out_valid = (state == SEND);
    out_data  = (state == SEND) ? ram_rdata[{b, 3'b000} +: 8] : 8'h00;
    out_last  = (state == SEND) && (w == ADDR_W'(DUMP_WORDS - 1)) && (b == 2'd3);
    dump_done = done_q;
  end

endmodule
